// File: rtl/matrix_opposite_ctrl.sv
// matrix_opposite_ctrl: negates a 5x5 matrix of signed bytes element by
// element, reading from src_base and writing to dst_base (in place allowed).
// Each element takes three cycles: RD (read strobe), CAP (capture data),
// WR (write the negated value).
// Optional build macro OPPOSITE_SATURATE_EN: -128 is written as +127
// instead of wrapping to -128.
module matrix_opposite_ctrl #(
  parameter int ADDR_W = 8,
  parameter int N_ELEM = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow_flag
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        elem_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;

  // Two's-complement negation of one element, optionally saturating -128.
  function automatic logic [7:0] negate(input logic [7:0] v);
`ifdef OPPOSITE_SATURATE_EN
    if (v == 8'h80) begin
      return 8'h7F;
    end
`endif
    return 8'h00 - v;
  endfunction

  assign idx_inc = idx_q + 1'b1;

  // Sequencer: state, element index, captured bases and all strobes/addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      elem_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      // Strobes and addresses are single-cycle; zero unless set below.
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q     <= src_base;
            dst_q     <= dst_base;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= src_base;
            state_q   <= S_RD;
          end
        end
        S_RD: begin
          state_q <= S_CAP;
        end
        S_CAP: begin
          elem_q <= mem_rd_data;
          if (mem_rd_data == 8'h80) begin
            ovf_q <= 1'b1;
          end
          wr_en_q   <= 1'b1;
          wr_addr_q <= dst_q + ADDR_W'(idx_q);
          state_q   <= S_WR;
        end
        S_WR: begin
          idx_q <= idx_inc;
          if (idx_q < LAST_IDX) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= src_q + ADDR_W'(idx_inc);
            state_q   <= S_RD;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en     = rd_en_q;
  assign mem_rd_addr   = rd_addr_q;
  assign mem_wr_en     = wr_en_q;
  assign mem_wr_addr   = wr_addr_q;
  // Write data is formed from the captured element and forced to zero off-strobe.
  assign mem_wr_data   = wr_en_q ? negate(elem_q) : 8'h00;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_matrix_opposite_ctrl.sv
// Scoreboard bench for matrix_opposite_ctrl with a byte-wide memory model.
module tb_matrix_opposite_ctrl;

  localparam int AW = 8;
  localparam int N  = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [7:0]    mem_wr_data;
  logic          busy;
  logic          done;
  logic          overflow_flag;

  matrix_opposite_ctrl #(.ADDR_W(AW), .N_ELEM(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .overflow_flag(overflow_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int addr; int data; } acc_t;
  typedef struct { int cyc; int ovf; } done_t;

  acc_t  rd_q[$];
  acc_t  wr_q[$];
  done_t dn_q[$];

  logic [7:0] mem [256];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: one-cycle read latency, garbage on the read bus otherwise.
  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 8'($urandom);
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference negation from plain integer arithmetic.
  function automatic int ref_neg(input int v);
    int r;
    r = (256 - v) % 256;
`ifdef OPPOSITE_SATURATE_EN
    if (v == 128) r = 127;
`endif
    return r;
  endfunction

  // Expected transactions for a run whose first read occurs in cycle acc.
  task automatic push_expect(input int src, input int dst, input int acc);
    int ovf;
    int a;
    int v;
    ovf = 0;
    for (int i = 0; i < N; i++) begin
      a = (src + i) % 256;
      v = int'(mem[a]);
      if (v == 128) ovf = 1;
      rd_q.push_back('{cyc: acc + 3 * i, addr: a, data: 0});
      wr_q.push_back('{cyc: acc + 3 * i + 2, addr: (dst + i) % 256, data: ref_neg(v)});
    end
    dn_q.push_back('{cyc: acc + 3 * N, ovf: ovf});
  endtask

  task automatic run(input int src, input int dst);
    int acc;
    @(negedge clk);
    src_base = AW'(src);
    dst_base = AW'(dst);
    start = 1'b1;
    acc = cyc + 1;
    push_expect(src, dst, acc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((rd_q.size() + wr_q.size() + dn_q.size()) != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_completes"}, rd_q.size() + wr_q.size() + dn_q.size(), 0);
    rd_q.delete(); wr_q.delete(); dn_q.delete();
    @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_rd_en"}, int'(mem_rd_en), 0);
    chk({nm, "_rd_addr"}, int'(mem_rd_addr), 0);
    chk({nm, "_wr_en"}, int'(mem_wr_en), 0);
    chk({nm, "_wr_addr"}, int'(mem_wr_addr), 0);
    chk({nm, "_wr_data"}, int'(mem_wr_data), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_ovf"}, int'(overflow_flag), 0);
  endtask

  // Monitor: protocol invariants plus scoreboard pops on every strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      acc_t  e;
      done_t d;
      if (mem_rd_en && mem_wr_en) chk("rd_wr_overlap", 1, 0);
      if (!mem_rd_en && mem_rd_addr != '0) chk("rd_addr_idle_zero", int'(mem_rd_addr), 0);
      if (!mem_wr_en && (mem_wr_addr != '0 || mem_wr_data != '0))
        chk("wr_bus_idle_zero", int'({mem_wr_addr, mem_wr_data}), 0);
      if (mem_rd_en) begin
        if (rd_q.size() == 0) chk("unexpected_rd", int'(mem_rd_addr), -1);
        else begin
          e = rd_q.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", int'(mem_rd_addr), e.addr);
          chk("rd_busy", int'(busy), 1);
        end
      end
      if (mem_wr_en) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("unexpected_wr", int'(mem_wr_addr), -1);
        else begin
          e = wr_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", int'(mem_wr_addr), e.addr);
          chk("wr_data", int'(mem_wr_data), e.data);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = dn_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_ovf", int'(overflow_flag), d.ovf);
          chk("done_busy", int'(busy), 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int src;
    int dst;
    int acc1;
    int acc2;
    int target;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // Case 1: ramp 0..24 to 0x40.
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    run(8'h00, 8'h40);
    drain("ramp");
    chk("ramp_mem41", int'(mem[8'h41]), 8'hFF);
    chk("ramp_mem58", int'(mem[8'h58]), 8'hE8);

    // Case 2: one -128 element among 5s.
    for (int i = 0; i < N; i++) mem[8'h80 + i] = 8'h05;
    mem[8'h87] = 8'h80;
    run(8'h80, 8'hC0);
    drain("minus128");

    // Case 3: in place across the address wrap.
    for (int i = 0; i < N; i++) mem[(8'hF0 + i) % 256] = 8'($urandom);
    run(8'hF0, 8'hF0);
    drain("wrap_inplace");

    // Case 4: stray start pulses mid-run are ignored.
    for (int i = 0; i < N; i++) mem[8'h20 + i] = 8'($urandom);
    run(8'h20, 8'hA0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("stray_start");

    // Case 5: reset after the 12th write, then rerun from idx 0.
    for (int i = 0; i < N; i++) mem[8'h30 + i] = 8'($urandom);
    mem[8'h33] = 8'h80;
    target = wr_cnt + 12;
    run(8'h30, 8'hB0);
    for (int k = 0; k < 200 && wr_cnt < target; k++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_12_writes", int'(wr_cnt >= target), 1);
    chk("ovf_before_reset", int'(overflow_flag), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 check_zero("midrun_reset");
    rd_q.delete(); wr_q.delete(); dn_q.delete();
    @(negedge clk);
    reset = 1'b0;
    run(8'h30, 8'hB0);
    drain("after_reset");

    // Case 6: start held high, two back-to-back runs, flag cleared on accept.
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    mem[2] = 8'h80;
    for (int i = 0; i < N; i++) mem[8'h80 + i] = 8'($urandom_range(0, 127));
    @(negedge clk);
    src_base = 8'h00;
    dst_base = 8'h60;
    start = 1'b1;
    acc1 = cyc + 1;
    acc2 = acc1 + 3 * N + 2;
    push_expect(8'h00, 8'h60, acc1);
    push_expect(8'h80, 8'hE0, acc2);
    @(negedge clk);
    src_base = 8'h80;
    dst_base = 8'hE0;
    while (cyc < acc1 + 3 * N + 1) @(negedge clk);
    chk("gap_busy_low", int'(busy), 0);
    chk("gap_ovf_held", int'(overflow_flag), 1);
    while (cyc < acc2) @(negedge clk);
    start = 1'b0;
    drain("back_to_back");

    // Randomised runs: disjoint or in-place, occasional -128 elements.
    for (int r = 0; r < 4; r++) begin
      src = int'($urandom_range(0, 255));
      dst = ($urandom_range(0, 1) == 0) ? src : (src ^ 128);
      for (int i = 0; i < N; i++)
        mem[(src + i) % 256] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      run(src, dst);
      drain("random");
    end

    chk("rd_queue_empty", rd_q.size(), 0);
    chk("wr_queue_empty", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
